// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the SRAM bus arbiter.
package sram_bus_arbiter_pkg;

    localparam int NMST = 3;

    localparam logic [1:0] MST_DBG  = 2'd0;
    localparam logic [1:0] MST_DATA = 2'd1;
    localparam logic [1:0] MST_INST = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RSP = 3'd2,
        RESP     = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    // One-hot master vector for a master index.
    function automatic logic [NMST-1:0] mst_onehot(input logic [1:0] idx);
        mst_onehot = {{(NMST-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle between the three masters, the arbiter and the RAM model.
interface sram_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import sram_bus_arbiter_pkg::*;

    // Master side
    logic [NMST-1:0]        m_valid;
    logic [NMST-1:0]        m_ready;
    logic [NMST-1:0]        m_we;
    logic [NMST*AW-1:0]     m_addr;
    logic [NMST*DW-1:0]     m_wdata;
    logic [NMST*DW/8-1:0]   m_wstrb;
    logic [NMST-1:0]        m_rsp_valid;
    logic [DW-1:0]          m_rsp_rdata;
    logic                   m_rsp_err;
    logic                   dbg_lock;
    // Memory side
    logic                   mem_req;
    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;
    logic [DW/8-1:0]        mem_wstrb;
    logic                   mem_ready;
    logic                   mem_rvalid;
    logic [DW-1:0]          mem_rdata;
    // Status
    logic                   busy;

    // Arbiter view
    modport slave (
        input  m_valid, m_we, m_addr, m_wdata, m_wstrb, dbg_lock,
               mem_ready, mem_rvalid, mem_rdata,
        output m_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

    // Environment view: requesters plus RAM
    modport master (
        output m_valid, m_we, m_addr, m_wdata, m_wstrb, dbg_lock,
               mem_ready, mem_rvalid, mem_rdata,
        input  m_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

endinterface

// File: rtl/sram_bus_arbiter_rr_arb2.sv
// Two-way round-robin between the data port (index 0) and the
// instruction fetch (index 1). The pointer moves to the loser side
// whenever the parent actually takes this arbiter's grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);
    logic r_ptr;

    // Pick the favoured requester when both ask, otherwise the only one.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        o_gnt_valid = |i_req;
        o_gnt_idx   = 1'b0;
        if (i_req == 2'b11) begin
            o_gnt_idx = r_ptr;
        end else if (i_req[1]) begin
            o_gnt_idx = 1'b1;
        end
    end

    // Favour the other requester after each taken grant.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~o_gnt_idx;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Single-outstanding arbiter/sequencer for the shared SRAM bus:
// dbg has fixed priority, data/inst share a round-robin, responses are
// routed back to the owner, and a silent RAM is recovered by a timeout.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    sram_bus_arbiter_if.slave bus
);
    localparam int         SW      = DW / 8;
    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_g;
    logic [7:0]       r_cnt;
    logic             r_mem_we;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic [SW-1:0]    r_mem_wstrb;
    logic [NMST-1:0]  r_rsp_valid;
    logic             r_rsp_err;
    logic [DW-1:0]    r_rsp_rdata;

    logic             w_grant;
    logic [1:0]       w_win;
    logic             w_rr_adv;
    logic             w_timeout;
    logic [1:0]       w_rr_req;
    logic             w_rr_valid;
    logic             w_rr_idx;

    // dbg_lock hides data and inst from the round-robin.
    assign w_rr_req = {bus.m_valid[MST_INST], bus.m_valid[MST_DATA]} & {2{~bus.dbg_lock}};

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_rr_req),
        .i_advance   (w_rr_adv),
        .o_gnt_valid (w_rr_valid),
        .o_gnt_idx   (w_rr_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, arbitration (IDLE only) and timeout detection.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_win        = MST_DBG;
        w_rr_adv     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.m_valid[MST_DBG]) begin
                    w_grant = 1'b1;
                    w_win   = MST_DBG;
                end else if (w_rr_valid) begin
                    w_grant  = 1'b1;
                    w_win    = w_rr_idx ? MST_INST : MST_DATA;
                    w_rr_adv = 1'b1;
                end
                if (w_grant) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    w_next_state = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.mem_rvalid) begin
                    w_next_state = RESP;
                end else if (r_cnt == TMO_CNT) begin
                    w_timeout    = 1'b1;
                    w_next_state = DRAIN;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            DRAIN: begin
                // The late response is swallowed here.
                if (bus.mem_rvalid) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Grant payload capture, wait counter and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g         <= MST_DBG;
            r_cnt       <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_g         <= w_win;
                r_mem_we    <= bus.m_we[w_win];
                r_mem_addr  <= bus.m_addr[int'(w_win) * AW +: AW];
                r_mem_wdata <= bus.m_wdata[int'(w_win) * DW +: DW];
                r_mem_wstrb <= bus.m_wstrb[int'(w_win) * SW +: SW];
            end

            if (r_state == REQ && bus.mem_ready) begin
                r_cnt <= 8'd0;
            end else if (r_state == WAIT_RSP) begin
                r_cnt <= r_cnt + 8'd1;
            end

            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            if (r_state == WAIT_RSP && bus.mem_rvalid) begin
                r_rsp_valid <= mst_onehot(r_g);
                r_rsp_rdata <= bus.mem_rdata;
            end else if (w_timeout) begin
                r_rsp_valid <= mst_onehot(r_g);
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign bus.mem_req     = (r_state == REQ);
    assign bus.m_ready     = (r_state == REQ && bus.mem_ready) ? mst_onehot(r_g) : '0;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_wstrb   = r_mem_wstrb;
    assign bus.m_rsp_valid = r_rsp_valid;
    assign bus.m_rsp_err   = r_rsp_err;
    assign bus.m_rsp_rdata = r_rsp_rdata;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomised bench for sram_bus_arbiter. The bench plays all three
// masters and the RAM; a transaction-level model (pending flags, rr bit,
// word-addressed RAM array) predicts winners, payloads and responses.
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sram_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit              pend    [3];
    bit              p_we    [3];
    logic [AW-1:0]   p_addr  [3];
    logic [DW-1:0]   p_wdata [3];
    logic [SW-1:0]   p_wstrb [3];
    bit              model_rr;
    logic [DW-1:0]   ram [logic [AW-1:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ram_read(input logic [AW-1:0] a);
        if (ram.exists(a)) return ram[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic ram_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] cur;
        cur = ram_read(a);
        for (int b = 0; b < SW; b++) begin
            if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        end
        ram[a] = cur;
    endtask

    // Winner by the arbitration rules: dbg first, lock masks data/inst, rr breaks ties.
    function automatic int model_pick(input bit lock);
        if (pend[0]) return 0;
        if (lock) return -1;
        if (pend[1] && pend[2]) return model_rr ? 2 : 1;
        if (pend[1]) return 1;
        if (pend[2]) return 2;
        return -1;
    endfunction

    task automatic drive_masters();
        for (int i = 0; i < 3; i++) begin
            bus.m_valid[i]          = pend[i];
            bus.m_we[i]             = p_we[i];
            bus.m_addr[i*AW +: AW]  = p_addr[i];
            bus.m_wdata[i*DW +: DW] = p_wdata[i];
            bus.m_wstrb[i*SW +: SW] = p_wstrb[i];
        end
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        pend[i]    = 1'b1;
        p_we[i]    = we;
        p_addr[i]  = a;
        p_wdata[i] = d;
        p_wstrb[i] = s;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)) << 2,
                DW'($urandom), SW'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   bus.mem_req, 0);
        check({tag, "_mem_we"},    bus.mem_we, 0);
        check({tag, "_mem_addr"},  bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_mem_wstrb"}, bus.mem_wstrb, 0);
        check({tag, "_m_ready"},   bus.m_ready, 0);
        check({tag, "_rsp_valid"}, bus.m_rsp_valid, 0);
        check({tag, "_rsp_err"},   bus.m_rsp_err, 0);
        check({tag, "_rsp_rdata"}, bus.m_rsp_rdata, 0);
        check({tag, "_busy"},      bus.busy, 0);
    endtask

    // One arbitration opportunity starting at a negedge with the DUT in IDLE.
    task automatic txn(input bit lock, input int rdy_dly, input int rsp_dly,
                       input bit tmo, input int drain_len, input bit rst_mid);
        int            win;
        logic [2:0]    oh;
        logic [DW-1:0] exp_rd;
        bit            was_wr;

        check("idle_busy", bus.busy, 0);
        bus.dbg_lock   = lock;
        bus.mem_ready  = 1'($urandom_range(0, 1));
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata  = DW'($urandom);
        drive_masters();
        win = model_pick(lock);
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_ready  = 1'b0;
        if (win < 0) begin
            check("nogrant_req", bus.mem_req, 0);
            check("nogrant_busy", bus.busy, 0);
            return;
        end
        if (win == 1) model_rr = 1'b1;
        if (win == 2) model_rr = 1'b0;
        oh = 3'b001 << win;

        // REQ: payload must be the winner's, held until mem_ready
        for (int k = 0; k <= rdy_dly; k++) begin
            check("req_mem_req", bus.mem_req, 1);
            check("req_addr",  bus.mem_addr,  p_addr[win]);
            check("req_wdata", bus.mem_wdata, p_wdata[win]);
            check("req_wstrb", bus.mem_wstrb, p_wstrb[win]);
            check("req_we",    bus.mem_we,    p_we[win]);
            bus.mem_ready  = (k == rdy_dly);
            bus.mem_rvalid = (k == rdy_dly) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            check("m_ready", bus.m_ready, (k == rdy_dly) ? oh : 3'b000);
            tick();
        end
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;

        was_wr = p_we[win];
        exp_rd = ram_read(p_addr[win]);
        if (was_wr) ram_write(p_addr[win], p_wdata[win], p_wstrb[win]);
        pend[win] = 1'b0;
        drive_masters();

        if (rst_mid) begin
            check("wait_busy_pre_rst", bus.busy, 1);
            rst = 1'b1;
            #1;
            check_all_zero("rst_mid");
            model_rr = 1'b0;
            tick();
            check_all_zero("rst_hold");
            rst = 1'b0;
            return;
        end

        if (!tmo) begin
            for (int k = 0; k < rsp_dly; k++) begin
                check("wait_rsp_valid", bus.m_rsp_valid, 0);
                check("wait_mem_req", bus.mem_req, 0);
                check("wait_busy", bus.busy, 1);
                tick();
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = was_wr ? DW'($urandom) : exp_rd;
            tick();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = DW'($urandom);
            check("resp_valid", bus.m_rsp_valid, oh);
            check("resp_err", bus.m_rsp_err, 0);
            if (!was_wr) check("resp_rdata", bus.m_rsp_rdata, exp_rd);
            check("resp_busy", bus.busy, 1);
            tick();
            check("post_resp_valid", bus.m_rsp_valid, 0);
        end else begin
            for (int k = 0; k <= TMO; k++) begin
                bus.mem_rdata = DW'($urandom);
                check("tmo_wait_valid", bus.m_rsp_valid, 0);
                check("tmo_wait_req", bus.mem_req, 0);
                tick();
            end
            check("tmo_valid", bus.m_rsp_valid, oh);
            check("tmo_err", bus.m_rsp_err, 1);
            check("tmo_rdata", bus.m_rsp_rdata, 0);
            check("tmo_busy", bus.busy, 1);
            for (int k = 0; k < drain_len; k++) begin
                for (int i = 0; i < 3; i++) if (!pend[i]) rand_req(i);
                drive_masters();
                tick();
                check("drain_valid", bus.m_rsp_valid, 0);
                check("drain_req", bus.mem_req, 0);
                check("drain_busy", bus.busy, 1);
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = DW'($urandom);
            #1;
            check("drain_m_ready", bus.m_ready, 0);
            tick();
            bus.mem_rvalid = 1'b0;
            check("drop_valid", bus.m_rsp_valid, 0);
            check("drop_req", bus.mem_req, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.m_valid    = '0;
        bus.m_we       = '0;
        bus.m_addr     = '0;
        bus.m_wdata    = '0;
        bus.m_wstrb    = '0;
        bus.dbg_lock   = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        model_rr       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; p_wstrb[i] = '0;
        end
        ram[32'h100] = 32'hDEADBEEF;

        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single read from inst at 0x100, rvalid two cycles after mem_ready
        set_req(2, 1'b0, 32'h100, 32'h0, 4'h0);
        txn(1'b0, 0, 1, 1'b0, 0, 1'b0);

        // data and inst continuously valid: alternate, starting with data
        set_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h44, 32'h0, 4'h0);
        for (int n = 0; n < 4; n++) begin
            txn(1'b0, n % 2, n, 1'b0, 0, 1'b0);
            if (!pend[1]) set_req(1, 1'b0, 32'h48, 32'h0, 4'h0);
            if (!pend[2]) set_req(2, 1'b0, 32'h4C, 32'h0, 4'h0);
        end

        // dbg wins over both, then lock with dbg idle blocks, then data
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        txn(1'b0, 1, 0, 1'b0, 0, 1'b0);
        txn(1'b1, 0, 0, 1'b0, 0, 1'b0);
        txn(1'b1, 0, 0, 1'b0, 0, 1'b0);
        txn(1'b0, 0, 0, 1'b0, 0, 1'b0);

        // Write from data
        pend[2] = 1'b0;
        set_req(1, 1'b1, 32'h20, 32'h12345678, 4'b0011);
        txn(1'b0, 2, 2, 1'b0, 0, 1'b0);
        set_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
        txn(1'b0, 0, 0, 1'b0, 0, 1'b0);

        // Timeout with late rvalid dropped; boundary response at cnt == TIMEOUT
        set_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
        txn(1'b0, 0, 0, 1'b1, 3, 1'b0);
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        set_req(2, 1'b0, 32'hC, 32'h0, 4'h0);
        txn(1'b0, 0, TMO, 1'b0, 0, 1'b0);

        // Reset in WAIT_RSP with rr = 1, then data wins afresh
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        txn(1'b0, 0, 0, 1'b0, 0, 1'b0);
        set_req(0, 1'b0, 32'h14, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h18, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h1C, 32'h0, 4'h0);
        txn(1'b0, 0, 0, 1'b0, 0, 1'b1);
        txn(1'b0, 0, 0, 1'b0, 0, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) rand_req(i);
            end
            txn(($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, TMO),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3), ($urandom_range(0, 29) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
